// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads, fills IF/ID,
// absorbs redirects, ID stalls and branch-operand stalls (count_B).
module fetch_unit #(
  parameter int unsigned          WORD_SIZE    = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC     = 16'h0000,
  parameter logic [WORD_SIZE-1:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] i_predict_PC,
  input  logic                 i_redirect,
  input  logic [WORD_SIZE-1:0] i_redirect_PC,
  input  logic                 i_stall,
  input  logic                 i_branch_stall,
  input  logic [3:0]           i_branch_limit,
  input  logic                 i_inputReady,
  input  logic [WORD_SIZE-1:0] i_data,
  output logic                 o_readM,
  output logic [WORD_SIZE-1:0] o_address,
  output logic [WORD_SIZE-1:0] o_PC,
  output logic [WORD_SIZE-1:0] o_IFID_instr,
  output logic [WORD_SIZE-1:0] o_IFID_PC,
  output logic [WORD_SIZE-1:0] o_IFID_predPC,
  output logic                 o_IFID_valid,
  output logic [3:0]           o_count_B,
  output logic [WORD_SIZE-1:0] o_num_fetch
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, BSTALL} state_t;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic                 r_readM;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] r_ifid_instr;
  logic [WORD_SIZE-1:0] r_ifid_pc;
  logic [WORD_SIZE-1:0] r_ifid_pred;
  logic                 r_ifid_valid;
  logic [WORD_SIZE-1:0] r_hold_instr;
  logic [WORD_SIZE-1:0] r_hold_pc;
  logic [WORD_SIZE-1:0] r_hold_pred;
  logic [3:0]           r_count_b;
  logic [3:0]           r_limit;
  logic [WORD_SIZE-1:0] r_num_fetch;

  logic                 w_bstall_take;
  logic [3:0]           w_limit;

  // A branch stall only applies to a real IF/ID instruction and never re-arms while counting.
  assign w_bstall_take = i_branch_stall && r_ifid_valid && (r_count_b == 4'd0) &&
                         ((r_state == REQ) || (r_state == HOLD));
  assign w_limit       = (i_branch_limit == 4'd0) ? 4'd1 : i_branch_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_readM      <= 1'b0;
      r_pc         <= RESET_PC;
      r_ifid_instr <= BUBBLE_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_pred  <= '0;
      r_ifid_valid <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_hold_pred  <= '0;
      r_count_b    <= 4'd0;
      r_limit      <= 4'd1;
      r_num_fetch  <= '0;
    end else if (i_redirect) begin
      r_pc         <= i_redirect_PC;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= BUBBLE_INSTR;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_hold_pred  <= '0;
      r_count_b    <= 4'd0;
      r_state      <= REQ;
      r_readM      <= 1'b1;
    end else if (w_bstall_take) begin
      r_limit   <= w_limit;
      r_count_b <= 4'd1;
      r_state   <= BSTALL;
      r_readM   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_readM <= 1'b1;
        end
        REQ: begin
          if (i_inputReady) begin
            if (i_stall) begin
              r_hold_instr <= i_data;
              r_hold_pc    <= r_pc;
              r_hold_pred  <= i_predict_PC;
              r_state      <= HOLD;
              r_readM      <= 1'b0;
            end else begin
              r_ifid_instr <= i_data;
              r_ifid_pc    <= r_pc;
              r_ifid_pred  <= i_predict_PC;
              r_ifid_valid <= 1'b1;
              r_pc         <= i_predict_PC;
              r_num_fetch  <= r_num_fetch + ONE;
            end
          end else if (!i_stall) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= BUBBLE_INSTR;
          end
        end
        HOLD: begin
          if (!i_stall) begin
            r_ifid_instr <= r_hold_instr;
            r_ifid_pc    <= r_hold_pc;
            r_ifid_pred  <= r_hold_pred;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_hold_pred;
            r_num_fetch  <= r_num_fetch + ONE;
            r_state      <= REQ;
            r_readM      <= 1'b1;
          end
        end
        BSTALL: begin
          if (r_count_b == r_limit) begin
            r_count_b <= 4'd0;
            r_state   <= REQ;
            r_readM   <= 1'b1;
          end else begin
            r_count_b <= r_count_b + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_readM <= 1'b0;
        end
      endcase
    end
  end

  assign o_readM       = r_readM;
  assign o_address     = r_pc;
  assign o_PC          = r_pc;
  assign o_IFID_instr  = r_ifid_instr;
  assign o_IFID_PC     = r_ifid_pc;
  assign o_IFID_predPC = r_ifid_pred;
  assign o_IFID_valid  = r_ifid_valid;
  assign o_count_B     = r_count_b;
  assign o_num_fetch   = r_num_fetch;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, redirect, ID stall,
// branch stall counting, slow memory and mid-stall async reset with PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [15:0] i_predict_PC;
  logic        i_redirect;
  logic [15:0] i_redirect_PC;
  logic        i_stall;
  logic        i_branch_stall;
  logic [3:0]  i_branch_limit;
  logic        i_inputReady;
  logic [15:0] i_data;
  logic        o_readM;
  logic [15:0] o_address;
  logic [15:0] o_PC;
  logic [15:0] o_IFID_instr;
  logic [15:0] o_IFID_PC;
  logic [15:0] o_IFID_predPC;
  logic        o_IFID_valid;
  logic [3:0]  o_count_B;
  logic [15:0] o_num_fetch;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000), .BUBBLE_INSTR(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_predict_PC(i_predict_PC), .i_redirect(i_redirect), .i_redirect_PC(i_redirect_PC),
    .i_stall(i_stall), .i_branch_stall(i_branch_stall), .i_branch_limit(i_branch_limit),
    .i_inputReady(i_inputReady), .i_data(i_data),
    .o_readM(o_readM), .o_address(o_address), .o_PC(o_PC),
    .o_IFID_instr(o_IFID_instr), .o_IFID_PC(o_IFID_PC), .o_IFID_predPC(o_IFID_predPC),
    .o_IFID_valid(o_IFID_valid), .o_count_B(o_count_B), .o_num_fetch(o_num_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory returns 16'h1000+addr and the predictor says addr+1.
  task automatic mem_seq();
    i_data       = 16'h1000 + o_PC;
    i_predict_PC = o_PC + 16'h0001;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; i_redirect = 0; i_redirect_PC = 0; i_stall = 0; i_branch_stall = 0;
    i_branch_limit = 0; i_inputReady = 1'b1; i_data = 0; i_predict_PC = 0;
    #2 reset_n = 1'b0;
    #2;
    checks++; if (o_PC !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", o_PC); end
    checks++; if (o_readM !== 1'b0) begin errors++; $display("FAIL reset_readM got=%b exp=0", o_readM); end
    checks++; if (o_IFID_valid !== 1'b0 || o_IFID_instr !== 16'h0000)
      begin errors++; $display("FAIL reset_ifid got=%b/%h exp=0/0000", o_IFID_valid, o_IFID_instr); end
    checks++; if (o_count_B !== 4'd0 || o_num_fetch !== 16'd0)
      begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", o_count_B, o_num_fetch); end
    tick(); tick();
    reset_n = 1'b1;
    mem_seq();
    tick();
    checks++; if (o_readM !== 1'b1 || o_address !== 16'h0000)
      begin errors++; $display("FAIL first_req got=%b/%h exp=1/0000", o_readM, o_address); end
  endtask

  task automatic test_seq_fetch();
    logic [15:0] exp_instr [3];
    exp_instr[0] = 16'h1000; exp_instr[1] = 16'h1001; exp_instr[2] = 16'h1002;
    for (int k = 0; k < 3; k++) begin
      mem_seq();
      tick();
      checks++;
      if (o_IFID_valid !== 1'b1 || o_IFID_instr !== exp_instr[k] || o_IFID_PC !== 16'(k) ||
          o_IFID_predPC !== 16'(k + 1))
        begin errors++; $display("FAIL seq_fetch%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", k, o_IFID_valid,
          o_IFID_instr, o_IFID_PC, o_IFID_predPC, exp_instr[k], 16'(k), 16'(k + 1)); end
    end
    checks++; if (o_num_fetch !== 16'd3 || o_PC !== 16'h0003)
      begin errors++; $display("FAIL seq_count got=%0d/%h exp=3/0003", o_num_fetch, o_PC); end
  endtask

  task automatic test_redirect();
    i_redirect = 1'b1; i_redirect_PC = 16'h0040; i_inputReady = 1'b1; i_data = 16'hAAAA;
    i_predict_PC = 16'h0004;
    tick();
    i_redirect = 1'b0;
    checks++; if (o_IFID_valid !== 1'b0 || o_IFID_instr === 16'hAAAA)
      begin errors++; $display("FAIL redirect_drop got=%b/%h exp=0/0000", o_IFID_valid, o_IFID_instr); end
    checks++; if (o_PC !== 16'h0040 || o_readM !== 1'b1 || o_num_fetch !== 16'd3)
      begin errors++; $display("FAIL redirect_pc got=%h/%b/%0d exp=0040/1/3", o_PC, o_readM, o_num_fetch); end
  endtask

  task automatic test_stall_hold();
    i_redirect = 1'b1; i_redirect_PC = 16'h0004; i_inputReady = 1'b0;
    tick();
    i_redirect = 1'b0; i_inputReady = 1'b1;
    mem_seq();
    tick();
    checks++; if (o_IFID_instr !== 16'h1004 || o_PC !== 16'h0005)
      begin errors++; $display("FAIL stall_pre got=%h/%h exp=1004/0005", o_IFID_instr, o_PC); end
    i_stall = 1'b1; i_data = 16'h2345; i_predict_PC = 16'h0077;
    for (int k = 0; k < 3; k++) begin
      tick();
      i_data = 16'h5555; i_predict_PC = 16'h0099;
      checks++;
      if (o_readM !== 1'b0 || o_IFID_instr !== 16'h1004 || o_IFID_PC !== 16'h0004 ||
          o_IFID_valid !== 1'b1 || o_PC !== 16'h0005)
        begin errors++; $display("FAIL stall_hold%0d got=%b/%h/%h/%b/%h exp=0/1004/0004/1/0005", k,
          o_readM, o_IFID_instr, o_IFID_PC, o_IFID_valid, o_PC); end
    end
    i_stall = 1'b0; i_inputReady = 1'b0;
    tick();
    checks++;
    if (o_IFID_instr !== 16'h2345 || o_IFID_PC !== 16'h0005 || o_IFID_predPC !== 16'h0077 ||
        o_IFID_valid !== 1'b1 || o_PC !== 16'h0077 || o_readM !== 1'b1 || o_num_fetch !== 16'd5)
      begin errors++; $display("FAIL stall_release got=%h/%h/%h/%b/%h/%b/%0d exp=2345/0005/0077/1/0077/1/5",
        o_IFID_instr, o_IFID_PC, o_IFID_predPC, o_IFID_valid, o_PC, o_readM, o_num_fetch); end
  endtask

  task automatic test_branch_stall();
    logic [3:0] exp_cnt [4];
    exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd3; exp_cnt[3] = 4'd0;
    i_branch_stall = 1'b1; i_branch_limit = 4'd3; i_inputReady = 1'b1;
    mem_seq();
    for (int k = 0; k < 4; k++) begin
      tick();
      i_branch_stall = 1'b0;
      checks++;
      if (o_count_B !== exp_cnt[k] || o_readM !== (k == 3) || o_PC !== 16'h0077 ||
          o_IFID_instr !== 16'h2345)
        begin errors++; $display("FAIL bstall3_%0d got=%0d/%b/%h/%h exp=%0d/%b/0077/2345", k, o_count_B,
          o_readM, o_PC, o_IFID_instr, exp_cnt[k], (k == 3)); end
    end
    mem_seq();
    tick();
    checks++; if (o_IFID_instr !== 16'h1077 || o_IFID_PC !== 16'h0077 || o_PC !== 16'h0078)
      begin errors++; $display("FAIL bstall_resume got=%h/%h/%h exp=1077/0077/0078", o_IFID_instr, o_IFID_PC, o_PC); end
    i_branch_stall = 1'b1; i_branch_limit = 4'd0;
    mem_seq();
    tick();
    i_branch_stall = 1'b0;
    checks++; if (o_count_B !== 4'd1 || o_readM !== 1'b0)
      begin errors++; $display("FAIL bstall0_a got=%0d/%b exp=1/0", o_count_B, o_readM); end
    tick();
    checks++; if (o_count_B !== 4'd0 || o_readM !== 1'b1 || o_PC !== 16'h0078)
      begin errors++; $display("FAIL bstall0_b got=%0d/%b/%h exp=0/1/0078", o_count_B, o_readM, o_PC); end
  endtask

  task automatic test_slow_mem();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'h0078; exp_pc[1] = 16'h0079; exp_pc[2] = 16'h0079; exp_pc[3] = 16'h007A;
    for (int k = 0; k < 4; k++) begin
      i_inputReady = (k % 2 == 1);
      mem_seq();
      tick();
      checks++;
      if (o_IFID_valid !== (k % 2 == 1) || o_PC !== exp_pc[k])
        begin errors++; $display("FAIL slow_mem%0d got=%b/%h exp=%b/%h", k, o_IFID_valid, o_PC,
          (k % 2 == 1), exp_pc[k]); end
    end
    checks++; if (o_IFID_instr !== 16'h1079 || o_num_fetch !== 16'd8)
      begin errors++; $display("FAIL slow_mem_last got=%h/%0d exp=1079/8", o_IFID_instr, o_num_fetch); end
  endtask

  task automatic test_wrap_and_reset();
    i_redirect = 1'b1; i_redirect_PC = 16'hFFFF; i_inputReady = 1'b0;
    tick();
    i_redirect = 1'b0; i_inputReady = 1'b1; i_data = 16'hBEEF; i_predict_PC = 16'h0000;
    tick();
    checks++; if (o_PC !== 16'h0000 || o_IFID_PC !== 16'hFFFF || o_IFID_instr !== 16'hBEEF || o_num_fetch !== 16'd9)
      begin errors++; $display("FAIL wrap got=%h/%h/%h/%0d exp=0000/FFFF/BEEF/9", o_PC, o_IFID_PC, o_IFID_instr, o_num_fetch); end
    i_branch_stall = 1'b1; i_branch_limit = 4'd5;
    tick();
    i_branch_stall = 1'b0;
    tick();
    checks++; if (o_count_B !== 4'd2)
      begin errors++; $display("FAIL pre_reset_cnt got=%0d exp=2", o_count_B); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (o_PC !== 16'h0000 || o_readM !== 1'b0 || o_IFID_valid !== 1'b0 || o_IFID_instr !== 16'h0000 ||
        o_IFID_PC !== 16'h0000 || o_IFID_predPC !== 16'h0000 || o_count_B !== 4'd0 || o_num_fetch !== 16'd0)
      begin errors++; $display("FAIL async_reset got=%h/%b/%b/%h/%h/%h/%0d/%0d exp=0000/0/0/0000/0000/0000/0/0",
        o_PC, o_readM, o_IFID_valid, o_IFID_instr, o_IFID_PC, o_IFID_predPC, o_count_B, o_num_fetch); end
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (o_readM !== 1'b1 || o_address !== 16'h0000 || o_count_B !== 4'd0)
      begin errors++; $display("FAIL post_reset got=%b/%h/%0d exp=1/0000/0", o_readM, o_address, o_count_B); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_redirect();
    test_stall_hold();
    test_branch_stall();
    test_slow_mem();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; owns the PC register and the instruction-memory read handshake.
- Drives PC into the branch predictor every cycle and takes the predictor's next_PC as the sequential/predicted successor.
- Fills the IF/ID pipeline register and accepts redirects from the branch/jump resolve stage.
- Generates the branch-stall cycle counter (count_B) consumed by the predictor and branch hazard logic.

Parameters:
- WORD_SIZE, 16, width of PC, address and instruction
- RESET_PC, 16'h0000, PC value loaded on reset
- BUBBLE_INSTR, 16'h0000, instruction field value written with valid=0

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- i_predict_PC  in  WORD_SIZE  predicted successor of o_PC (predictor next_PC)
- i_redirect  in  1  resolve stage flush (mispredict/jump)
- i_redirect_PC  in  WORD_SIZE  correct PC on redirect
- i_stall  in  1  ID data-hazard stall
- i_branch_stall  in  1  branch operand hazard for the IF/ID instruction
- i_branch_limit  in  4  count_B_limit for that hazard
- i_inputReady  in  1  memory data valid this cycle
- i_data  in  WORD_SIZE  instruction from memory
- o_readM  out  1  memory read request
- o_address  out  WORD_SIZE  read address (= o_PC)
- o_PC  out  WORD_SIZE  current fetch PC (to predictor PC)
- o_IFID_instr  out  WORD_SIZE  IF/ID instruction
- o_IFID_PC  out  WORD_SIZE  PC of IF/ID instruction
- o_IFID_predPC  out  WORD_SIZE  predicted successor recorded at fetch
- o_IFID_valid  out  1  IF/ID holds a real instruction
- o_count_B  out  4  branch-stall counter (to predictor count_B)
- o_num_fetch  out  WORD_SIZE  count of instructions delivered to IF/ID

Behaviour:
- Reset (async, while reset_n=0):
  - PC=RESET_PC, state IDLE, o_readM=0.
  - IF/ID fields = BUBBLE_INSTR/0/0, valid=0.
  - count_B=0, num_fetch=0, holding register cleared.
  - Reset asserted mid-operation aborts everything immediately.
- States:
  - IDLE: o_readM=0; next cycle goes to REQ.
  - REQ: o_readM=1, o_address=PC.
  - HOLD: o_readM=0; holds a fetched word while ID stalls.
  - BSTALL: o_readM=0; branch-stall counting.
- Priority each cycle: i_redirect > i_branch_stall > i_stall > normal fetch.
- Redirect, in any non-reset state:
  - PC<=i_redirect_PC; IF/ID valid<=0, instr<=BUBBLE_INSTR.
  - Holding register discarded; count_B<=0; state<=REQ.
  - Memory data arriving in the same cycle is dropped.
- Branch stall:
  - Sampled only in REQ/HOLD with count_B==0 and o_IFID_valid=1.
  - Latch limit L=max(i_branch_limit,1); count_B<=1; state<=BSTALL.
  - PC unchanged; data arriving that cycle is dropped and refetched later.
  - IF/ID held.
- BSTALL:
  - IF/ID held.
  - If count_B==L: count_B<=0, state<=REQ. Otherwise count_B<=count_B+1.
- REQ with i_inputReady=1, no redirect or branch stall:
  - i_stall=1: capture {i_data, PC, i_predict_PC} into the holding register; state<=HOLD; IF/ID unchanged.
  - i_stall=0: IF/ID<={i_data, PC, i_predict_PC, valid=1}; PC<=i_predict_PC; num_fetch+1.
- REQ with i_inputReady=0:
  - i_stall=1: IF/ID held.
  - i_stall=0: IF/ID valid<=0 (bubble).
  - PC unchanged; keep requesting.
- HOLD:
  - While i_stall=1: hold.
  - On i_stall=0: IF/ID<=holding register with valid=1; PC<=held predPC; num_fetch+1; state<=REQ.
- Arithmetic:
  - PC and num_fetch are WORD_SIZE wide and wrap modulo 2^WORD_SIZE (16'hFFFF+1=0).
  - count_B is 4-bit and never exceeds L.
- Timing: o_PC and o_address are register outputs. Fetch latency is 1 cycle from i_inputReady to IF/ID update.

Test Plan:
- Reset, release at cycle 0, i_inputReady=1 every cycle, predict=PC+1, data=16'h1000+PC -> cycle1 o_readM=1 addr 0; IF/ID then shows PC 0,1,2 with instr 16'h1000,1001,1002; o_num_fetch=3 after three deliveries.
- Redirect to 16'h0040 in the same cycle as i_inputReady with data 16'hAAAA -> 16'hAAAA never reaches IF/ID, valid=0 next cycle, o_PC=16'h0040.
- i_stall=1 for 3 cycles while data 16'h2345 arrives at PC 5 -> state HOLD, IF/ID unchanged; on release IF/ID=16'h2345/PC 5, o_PC=i_predict_PC captured at PC 5.
- i_branch_stall=1, i_branch_limit=3 -> o_count_B 1,2,3,0 on successive cycles with o_readM=0; fetch resumes at the unchanged PC; also i_branch_limit=0 -> count 1,0.
- Memory latency 2 cycles (i_inputReady every other cycle), i_stall=0 -> bubbles (valid=0) alternate with valid fetches; PC advances only on ready.
- reset_n pulsed low mid-BSTALL (count_B=2) and PC=16'hFFFF with predict 16'h0000 before that -> outputs return to reset values asynchronously; wrap case shows PC 16'hFFFF->16'h0000.
